// File: rtl/dataTypes_pkg.sv
// =============================================================================
// dataTypes_pkg: shared word, FSM-state and per-channel fetch config types.
// Rev 1.0
// =============================================================================
`default_nettype none

package dataTypes_pkg;

   typedef logic [31:0] mem_t;

   // Config fields are sized for the default main BRAM depth of 4096 words.
   localparam int CFG_AW = 12;

   typedef enum logic [1:0] {
      s_idle    = 2'd0,
      s_issue   = 2'd1,
      s_wait    = 2'd2,
      s_deliver = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [CFG_AW-1:0] base;
      logic [CFG_AW:0]   len;
      logic [CFG_AW-1:0] offset;
   } ch_fetch_cfg_t;

   // A zero length behaves like length one, so the same word repeats.
   function automatic logic [CFG_AW-1:0] next_offset(input logic [CFG_AW-1:0] off,
                                                     input logic [CFG_AW:0]   len);
      logic [CFG_AW:0] last;
      last = (len == '0) ? '0 : len - (CFG_AW+1)'(1);
      return ({1'b0, off} >= last) ? '0 : off + CFG_AW'(1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sig_fetch_server_rr_arbiter.sv
// =============================================================================
// rr_arbiter: combinational round-robin pick, searching from lastGrant+1.
// Rev 1.0
// =============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] lastGrant,
   output logic [$clog2(N)-1:0] grant,
   output logic                 anyReq
);

   localparam int IW = $clog2(N);

   // Scan farthest-to-nearest so the closest requester after lastGrant wins.
   always_comb begin
      logic [IW-1:0] idx;
      idx    = '0;
      grant  = '0;
      anyReq = 1'b0;
      for (int k = N; k >= 1; k--) begin
         idx = IW'((int'(lastGrant) + k) % N);
         if (req[idx]) begin
            grant  = idx;
            anyReq = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/sig_fetch_server.sv
// =============================================================================
// sig_fetch_server: serves per-channel word fetches from the shared main BRAM.
// Define SIG_FETCH_STATS_EN to add per-channel delivery counters (fetchCountDBG).
// Rev 1.0
// =============================================================================
`default_nettype none

module sig_fetch_server
   import dataTypes_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int MEM_DEPTH    = 4096,
   parameter int READ_LATENCY = 2
) (
   input  logic                         clk,
   input  logic                         resetN,
   input  logic                         cfgWrite,
   input  logic [$clog2(NUM_CH)-1:0]    cfgCh,
   input  logic [$clog2(MEM_DEPTH)-1:0] cfgBase,
   input  logic [$clog2(MEM_DEPTH):0]   cfgLen,
   input  logic [NUM_CH-1:0]            rewind,
   input  logic [NUM_CH-1:0]            request,
   output logic [$clog2(MEM_DEPTH)-1:0] memAddr,
   output logic                         memEn,
   input  mem_t                         memDout,
   output mem_t                         chData [NUM_CH],
   output logic [NUM_CH-1:0]            chValid,
   output logic [NUM_CH-1:0]            overrun,
   output logic                         busyDBG
`ifdef SIG_FETCH_STATS_EN
   ,
   output logic [NUM_CH-1:0][15:0]      fetchCountDBG
`endif
);

   localparam int AW  = $clog2(MEM_DEPTH);
   localparam int CW  = $clog2(NUM_CH);
   localparam int WCW = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;

   fetch_state_t        state_q;
   logic [CW-1:0]       grant_q;
   logic [CW-1:0]       lastGrant_q;
   logic [WCW-1:0]      waitCnt_q;
   logic                memEn_q;
   logic [AW-1:0]       memAddr_q;
   ch_fetch_cfg_t       cfg_q [NUM_CH];
   mem_t                chData_q [NUM_CH];
   logic [NUM_CH-1:0]   pending_q;
   logic [NUM_CH-1:0]   chValid_q;
   logic [NUM_CH-1:0]   overrun_q;
   logic [NUM_CH-1:0]   reqPrev_q;

   logic [CW-1:0]       arbGrant;
   logic                arbAny;
   logic [NUM_CH-1:0]   reqRise;
   logic [NUM_CH-1:0]   deliverVec;
   logic [NUM_CH-1:0]   cfgVec;

   rr_arbiter #(.N(NUM_CH)) u_arb (
      .req       (pending_q),
      .lastGrant (lastGrant_q),
      .grant     (arbGrant),
      .anyReq    (arbAny)
   );

   assign reqRise    = request & ~reqPrev_q;
   assign deliverVec = (state_q == s_deliver) ? (NUM_CH'(1) << grant_q) : '0;
   assign cfgVec     = cfgWrite ? (NUM_CH'(1) << cfgCh) : '0;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= s_idle;
         grant_q     <= '0;
         lastGrant_q <= '0;
         waitCnt_q   <= '0;
         memEn_q     <= 1'b0;
         memAddr_q   <= '0;
      end else begin
         case (state_q)
            s_idle: begin
               if (arbAny) begin
                  grant_q   <= arbGrant;
                  memEn_q   <= 1'b1;
                  memAddr_q <= cfg_q[arbGrant].base + cfg_q[arbGrant].offset;
                  state_q   <= s_issue;
               end
            end
            s_issue: begin
               memEn_q <= 1'b0;
               if (READ_LATENCY <= 1) begin
                  state_q <= s_deliver;
               end else begin
                  waitCnt_q <= WCW'(READ_LATENCY - 2);
                  state_q   <= s_wait;
               end
            end
            s_wait: begin
               if (waitCnt_q == '0) state_q <= s_deliver;
               else                 waitCnt_q <= waitCnt_q - WCW'(1);
            end
            s_deliver: begin
               lastGrant_q <= grant_q;
               state_q     <= s_idle;
            end
            default: state_q <= s_idle;
         endcase
      end
   end

   // A new rising request always re-arms pending, even in its own delivery cycle.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pending_q <= '0;
         chValid_q <= '0;
         overrun_q <= '0;
         reqPrev_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cfg_q[i]    <= '0;
            chData_q[i] <= '0;
         end
      end else begin
         reqPrev_q <= request;
         for (int i = 0; i < NUM_CH; i++) begin
            if (reqRise[i])         pending_q[i] <= 1'b1;
            else if (deliverVec[i]) pending_q[i] <= 1'b0;

            if (reqRise[i])         chValid_q[i] <= 1'b0;
            else if (deliverVec[i]) chValid_q[i] <= 1'b1;

            if (deliverVec[i]) chData_q[i] <= memDout;

            if (cfgVec[i])
               overrun_q[i] <= 1'b0;
            else if (reqRise[i] && pending_q[i] && !deliverVec[i])
               overrun_q[i] <= 1'b1;

            if (cfgVec[i]) begin
               cfg_q[i].base   <= cfgBase;
               cfg_q[i].len    <= cfgLen;
               cfg_q[i].offset <= '0;
            end else if (rewind[i]) begin
               cfg_q[i].offset <= '0;
            end else if (deliverVec[i]) begin
               cfg_q[i].offset <= next_offset(cfg_q[i].offset, cfg_q[i].len);
            end
         end
      end
   end

`ifdef SIG_FETCH_STATS_EN
   logic [NUM_CH-1:0][15:0] fetchCnt_q;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         fetchCnt_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (cfgVec[i])
               fetchCnt_q[i] <= '0;
            else if (deliverVec[i] && (fetchCnt_q[i] != 16'hFFFF))
               fetchCnt_q[i] <= fetchCnt_q[i] + 16'd1;
         end
      end
   end

   assign fetchCountDBG = fetchCnt_q;
`endif

   assign memEn   = memEn_q;
   assign memAddr = memAddr_q;
   assign chData  = chData_q;
   assign chValid = chValid_q;
   assign overrun = overrun_q;
   assign busyDBG = (state_q != s_idle);

endmodule

`default_nettype wire

// File: tb/tb_sig_fetch_server.sv
// =============================================================================
// tb_sig_fetch_server: directed self-checking bench with a 2-cycle BRAM model.
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_sig_fetch_server;
   import dataTypes_pkg::*;

   logic        clk = 1'b0;
   logic        resetN;
   logic        cfgWrite;
   logic [1:0]  cfgCh;
   logic [11:0] cfgBase;
   logic [12:0] cfgLen;
   logic [3:0]  rewind;
   logic [3:0]  request;
   logic [11:0] memAddr;
   logic        memEn;
   mem_t        memDout;
   mem_t        chData [4];
   logic [3:0]  chValid;
   logic [3:0]  overrun;
   logic        busyDBG;
`ifdef SIG_FETCH_STATS_EN
   logic [3:0][15:0] fetchCountDBG;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] mem  [4096];
   logic [31:0] pipe [2];

   always #5 clk = ~clk;

   // Two-cycle read latency BRAM model.
   always @(posedge clk) begin
      if (memEn) pipe[0] <= mem[memAddr];
      pipe[1] <= pipe[0];
   end
   assign memDout = pipe[1];

   sig_fetch_server #(.NUM_CH(4), .MEM_DEPTH(4096), .READ_LATENCY(2)) dut (
      .clk      (clk),
      .resetN   (resetN),
      .cfgWrite (cfgWrite),
      .cfgCh    (cfgCh),
      .cfgBase  (cfgBase),
      .cfgLen   (cfgLen),
      .rewind   (rewind),
      .request  (request),
      .memAddr  (memAddr),
      .memEn    (memEn),
      .memDout  (memDout),
      .chData   (chData),
      .chValid  (chValid),
      .overrun  (overrun),
      .busyDBG  (busyDBG)
`ifdef SIG_FETCH_STATS_EN
      ,
      .fetchCountDBG (fetchCountDBG)
`endif
   );

   task automatic do_cfg(input int ch, input logic [11:0] base, input logic [12:0] len);
      cfgWrite = 1'b1;
      cfgCh    = 2'(ch);
      cfgBase  = base;
      cfgLen   = len;
      @(negedge clk);
      cfgWrite = 1'b0;
   endtask

   // Raise request[ch] for 'hold' cycles; returns cycles until chValid[ch] (-1 on timeout).
   task automatic fetch(input int ch, input int hold, output int cyc, output logic [11:0] addr);
      cyc  = -1;
      addr = 12'hXXX;
      request[ch] = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == hold) request[ch] = 1'b0;
         if (memEn) addr = memAddr;
         if (chValid[ch]) begin
            cyc = c;
            break;
         end
      end
      request[ch] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      resetN = 1'b0; cfgWrite = 1'b0; cfgCh = '0; cfgBase = '0; cfgLen = '0;
      rewind = '0; request = '0;
      repeat (3) @(negedge clk);
      n_cmp++; if (memEn !== 1'b0) begin n_err++; $display("FAIL rst_memEn: got %b want 0", memEn); end
      n_cmp++; if (memAddr !== 12'h000) begin n_err++; $display("FAIL rst_memAddr: got %h want 000", memAddr); end
      n_cmp++; if (chValid !== 4'b0000) begin n_err++; $display("FAIL rst_chValid: got %b want 0000", chValid); end
      n_cmp++; if (overrun !== 4'b0000) begin n_err++; $display("FAIL rst_overrun: got %b want 0000", overrun); end
      n_cmp++; if (chData[0] !== 32'h0) begin n_err++; $display("FAIL rst_chData0: got %h want 0", chData[0]); end
      resetN = 1'b1;
      @(negedge clk);
      n_cmp++; if (busyDBG !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busyDBG); end
   endtask

   task automatic test_sequence();
      logic [31:0] exp_d [4];
      int          hold  [4];
      logic [11:0] exp_a [4];
      int          cyc;
      logic [11:0] addr;
      exp_d = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hAAAA_0001};
      exp_a = '{12'h010, 12'h011, 12'h012, 12'h010};
      hold  = '{1, 3, 1, 1};
      do_cfg(0, 12'h010, 13'd3);
      for (int k = 0; k < 4; k++) begin
         fetch(0, hold[k], cyc, addr);
         n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL seq_latency[%0d]: got %0d want 5", k, cyc); end
         n_cmp++; if (chData[0] !== exp_d[k]) begin n_err++; $display("FAIL seq_data[%0d]: got %h want %h", k, chData[0], exp_d[k]); end
         n_cmp++; if (addr !== exp_a[k]) begin n_err++; $display("FAIL seq_addr[%0d]: got %h want %h", k, addr, exp_a[k]); end
      end
   endtask

   task automatic test_all_channels();
      int         order [4];
      int         nseen;
      int         last_c;
      logic [3:0] prev;
      logic [3:0] newv;
      int         exp_o [4];
      exp_o = '{1, 2, 3, 0};
      order = '{-1, -1, -1, -1};
      nseen = 0; last_c = -1; prev = '0;
      do_cfg(1, 12'h040, 13'd1);
      do_cfg(2, 12'h050, 13'd1);
      do_cfg(3, 12'h060, 13'd1);
      request = 4'hF;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) request = 4'h0;
         newv = chValid & ~prev;
         for (int ch = 0; ch < 4; ch++) begin
            if (newv[ch] && nseen < 4) begin
               order[nseen] = ch;
               nseen++;
               last_c = c;
            end
         end
         prev = chValid;
         if (chValid == 4'hF) break;
      end
      for (int k = 0; k < 4; k++) begin
         n_cmp++; if (order[k] !== exp_o[k]) begin n_err++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, order[k], exp_o[k]); end
      end
      n_cmp++; if (chValid !== 4'hF) begin n_err++; $display("FAIL rr_valid: got %b want 1111", chValid); end
      n_cmp++; if (last_c < 0 || last_c > 20) begin n_err++; $display("FAIL rr_worst_case: got %0d cycles want <=20", last_c); end
      n_cmp++; if (chData[0] !== 32'hBBBB_0002) begin n_err++; $display("FAIL rr_data0: got %h want bbbb0002", chData[0]); end
      n_cmp++; if (chData[3] !== 32'h6666_0060) begin n_err++; $display("FAIL rr_data3: got %h want 66660060", chData[3]); end
      @(negedge clk);
   endtask

   task automatic test_overrun();
      int   rises;
      logic prev;
      do_cfg(2, 12'h050, 13'd1);
      rises = 0;
      request[2] = 1'b1;
      @(negedge clk); request[2] = 1'b0;
      prev = chValid[2];
      @(negedge clk); request[2] = 1'b1;
      @(negedge clk); request[2] = 1'b0;
      for (int c = 0; c < 25; c++) begin
         if (chValid[2] && !prev) rises++;
         prev = chValid[2];
         @(negedge clk);
      end
      n_cmp++; if (overrun !== 4'b0100) begin n_err++; $display("FAIL ovr_set: got %b want 0100", overrun); end
      n_cmp++; if (rises !== 1) begin n_err++; $display("FAIL ovr_deliveries: got %0d want 1", rises); end
      n_cmp++; if (chData[2] !== 32'h5555_0050) begin n_err++; $display("FAIL ovr_data: got %h want 55550050", chData[2]); end
      do_cfg(2, 12'h050, 13'd1);
      n_cmp++; if (overrun !== 4'b0000) begin n_err++; $display("FAIL ovr_clear: got %b want 0000", overrun); end
   endtask

   task automatic test_wrap();
      logic [11:0] exp_a [3];
      logic [31:0] exp_d [3];
      int          cyc;
      logic [11:0] addr;
      exp_a = '{12'hFFF, 12'h000, 12'hFFF};
      exp_d = '{32'hEEEE_0FFF, 32'h1111_0000, 32'hEEEE_0FFF};
      do_cfg(3, 12'hFFF, 13'd2);
      for (int k = 0; k < 3; k++) begin
         fetch(3, 1, cyc, addr);
         n_cmp++; if (addr !== exp_a[k]) begin n_err++; $display("FAIL wrap_addr[%0d]: got %h want %h", k, addr, exp_a[k]); end
         n_cmp++; if (chData[3] !== exp_d[k]) begin n_err++; $display("FAIL wrap_data[%0d]: got %h want %h", k, chData[3], exp_d[k]); end
      end
   endtask

   task automatic test_rewind();
      int          cyc;
      logic [11:0] addr;
      do_cfg(1, 12'h100, 13'd4);
      fetch(1, 1, cyc, addr);
      n_cmp++; if (chData[1] !== 32'h7777_0100) begin n_err++; $display("FAIL rew_first: got %h want 77770100", chData[1]); end
      request[1] = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) request[1] = 1'b0;
      end
      n_cmp++; if (busyDBG !== 1'b1) begin n_err++; $display("FAIL rew_busy: got %b want 1", busyDBG); end
      rewind[1] = 1'b1;
      @(negedge clk);
      rewind[1] = 1'b0;
      n_cmp++; if (chValid[1] !== 1'b1) begin n_err++; $display("FAIL rew_valid: got %b want 1", chValid[1]); end
      n_cmp++; if (chData[1] !== 32'h7777_0101) begin n_err++; $display("FAIL rew_data: got %h want 77770101", chData[1]); end
      @(negedge clk);
      fetch(1, 1, cyc, addr);
      n_cmp++; if (addr !== 12'h100) begin n_err++; $display("FAIL rew_next_addr: got %h want 100", addr); end
      n_cmp++; if (chData[1] !== 32'h7777_0100) begin n_err++; $display("FAIL rew_next_data: got %h want 77770100", chData[1]); end
   endtask

   task automatic test_async_reset();
      int bad_valid;
      int bad_en;
      request[0] = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         if (c == 1) request[0] = 1'b0;
      end
      n_cmp++; if (busyDBG !== 1'b1) begin n_err++; $display("FAIL ar_busy_before: got %b want 1", busyDBG); end
      #2 resetN = 1'b0;
      #1;
      n_cmp++; if (busyDBG !== 1'b0) begin n_err++; $display("FAIL ar_busy: got %b want 0", busyDBG); end
      n_cmp++; if (chData[1] !== 32'h0) begin n_err++; $display("FAIL ar_chData1: got %h want 0", chData[1]); end
      n_cmp++; if (chValid !== 4'b0000) begin n_err++; $display("FAIL ar_chValid: got %b want 0000", chValid); end
      n_cmp++; if (memAddr !== 12'h000) begin n_err++; $display("FAIL ar_memAddr: got %h want 000", memAddr); end
      @(negedge clk);
      @(negedge clk);
      resetN = 1'b1;
      bad_valid = 0; bad_en = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (chValid !== 4'b0000) bad_valid++;
         if (memEn !== 1'b0) bad_en++;
      end
      n_cmp++; if (bad_valid !== 0) begin n_err++; $display("FAIL ar_no_valid: got %0d cycles with chValid want 0", bad_valid); end
      n_cmp++; if (bad_en !== 0) begin n_err++; $display("FAIL ar_no_memEn: got %0d cycles with memEn want 0", bad_en); end
   endtask

   initial begin
      pipe[0] = '0;
      pipe[1] = '0;
      for (int i = 0; i < 4096; i++) mem[i] = 32'hD000_0000 + i;
      mem[12'h010] = 32'hAAAA_0001;
      mem[12'h011] = 32'hBBBB_0002;
      mem[12'h012] = 32'hCCCC_0003;
      mem[12'h040] = 32'h4444_0040;
      mem[12'h050] = 32'h5555_0050;
      mem[12'h060] = 32'h6666_0060;
      mem[12'h100] = 32'h7777_0100;
      mem[12'h101] = 32'h7777_0101;
      mem[12'hFFF] = 32'hEEEE_0FFF;
      mem[12'h000] = 32'h1111_0000;

      test_reset();
      test_sequence();
      test_all_channels();
      test_overrun();
      test_wrap();
      test_rewind();
      test_async_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
